// File: rtl/msrh_l1d_snoop_ctrl_if.sv
// Snoop front-end bundle: requester handshake, L1D/STQ s0 request and s1 result, line response.
// Latency: none, wires only.
// Backpressure: carried by snp_req_ready and snp_resp_ready; the s0/s1 buses have none.
//
// Port summary (slave = snoop controller, master = requester/L1D/STQ environment):
//   snp_req_*   : request valid/ready, line paddr, transaction tag
//   l1d_s0_*    : L1D snoop read request (valid, aligned paddr)
//   l1d_s1_*    : L1D result (valid, status, line data, valid bytes)
//   stq_s0_*    : STQ snoop request (valid, aligned paddr)
//   stq_s1_*    : STQ result (valid, committed-store data, byte enables)
//   snp_resp_*  : merged line response (valid/ready, data, be, hit, tag)
interface msrh_l1d_snoop_ctrl_if #(
    parameter int PADDR_W       = 56,
    parameter int DCACHE_DATA_W = 512,
    parameter int TAG_W         = 4
);
    localparam int DATA_B_W = DCACHE_DATA_W / 8;

    logic                     snp_req_valid;
    logic                     snp_req_ready;
    logic [PADDR_W-1:0]       snp_req_paddr;
    logic [TAG_W-1:0]         snp_req_tag;

    logic                     l1d_s0_valid;
    logic [PADDR_W-1:0]       l1d_s0_paddr;
    logic                     l1d_s1_valid;
    logic [1:0]               l1d_s1_status;
    logic [DCACHE_DATA_W-1:0] l1d_s1_data;
    logic [DATA_B_W-1:0]      l1d_s1_be;

    logic                     stq_s0_valid;
    logic [PADDR_W-1:0]       stq_s0_paddr;
    logic                     stq_s1_valid;
    logic [DCACHE_DATA_W-1:0] stq_s1_data;
    logic [DATA_B_W-1:0]      stq_s1_be;

    logic                     snp_resp_valid;
    logic                     snp_resp_ready;
    logic [DCACHE_DATA_W-1:0] snp_resp_data;
    logic [DATA_B_W-1:0]      snp_resp_be;
    logic                     snp_resp_hit;
    logic [TAG_W-1:0]         snp_resp_tag;

    modport slave (
        input  snp_req_valid, snp_req_paddr, snp_req_tag,
        input  l1d_s1_valid, l1d_s1_status, l1d_s1_data, l1d_s1_be,
        input  stq_s1_valid, stq_s1_data, stq_s1_be,
        input  snp_resp_ready,
        output snp_req_ready,
        output l1d_s0_valid, l1d_s0_paddr,
        output stq_s0_valid, stq_s0_paddr,
        output snp_resp_valid, snp_resp_data, snp_resp_be, snp_resp_hit, snp_resp_tag
    );

    modport master (
        output snp_req_valid, snp_req_paddr, snp_req_tag,
        output l1d_s1_valid, l1d_s1_status, l1d_s1_data, l1d_s1_be,
        output stq_s1_valid, stq_s1_data, stq_s1_be,
        output snp_resp_ready,
        input  snp_req_ready,
        input  l1d_s0_valid, l1d_s0_paddr,
        input  stq_s0_valid, stq_s0_paddr,
        input  snp_resp_valid, snp_resp_data, snp_resp_be, snp_resp_hit, snp_resp_tag
    );
endinterface

// File: rtl/msrh_l1d_snoop_ctrl.sv
// One-at-a-time coherence snoop: L1D+STQ s0 issue, s1 collect, conflict retry, store-over-line merge.
// Latency: response valid 3 cycles after accept; each L1D conflict adds 2+BACKOFF_CYC cycles.
// Backpressure: request ready only in IDLE; response registered and held until snp_resp_ready.
//
// Ports:
//   i_clk    : clock
//   i_reset  : asynchronous active-high reset; drops any in-flight snoop without a response
//   snp      : msrh_l1d_snoop_ctrl_if.slave (request, L1D s0/s1, STQ s0/s1, response)
module msrh_l1d_snoop_ctrl #(
    parameter int PADDR_W       = 56,
    parameter int DCACHE_DATA_W = 512,
    parameter int TAG_W         = 4,
    parameter int MAX_RETRY     = 7,
    parameter int BACKOFF_CYC   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    msrh_l1d_snoop_ctrl_if.slave  snp
);

    localparam int DATA_B_W = DCACHE_DATA_W / 8;
    localparam int OFS_W    = $clog2(DATA_B_W);
    localparam int RTRY_W   = $clog2(MAX_RETRY + 1);
    localparam int BOFF_W   = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;

    localparam logic [1:0] STS_HIT      = 2'd1;
    localparam logic [1:0] STS_CONFLICT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_BACKOFF,
        ST_RESP
    } state_t;

    state_t                   state_q, state_d;
    logic [PADDR_W-1:0]       paddr_q, paddr_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [RTRY_W-1:0]        retry_q, retry_d;
    logic [BOFF_W-1:0]        boff_q, boff_d;
    logic [DCACHE_DATA_W-1:0] resp_data_q, resp_data_d;
    logic [DATA_B_W-1:0]      resp_be_q, resp_be_d;
    logic                     resp_hit_q, resp_hit_d;

    logic                     l1d_hit;
    logic                     l1d_conflict;
    logic [DATA_B_W-1:0]      stq_be_eff;
    logic [DATA_B_W-1:0]      merge_be;
    logic [DCACHE_DATA_W-1:0] merge_data;

    // Offset bits inside the line are intentionally dropped.
    logic unused_paddr_lo;
    assign unused_paddr_lo = ^snp.snp_req_paddr[OFS_W-1:0];

    // A missing L1D response is a lost arbitration just like an explicit conflict.
    // NONE and MISS both contribute no L1D bytes.
    assign l1d_conflict = !snp.l1d_s1_valid || (snp.l1d_s1_status == STS_CONFLICT);
    assign l1d_hit      = snp.l1d_s1_valid && (snp.l1d_s1_status == STS_HIT);
    assign stq_be_eff   = snp.stq_s1_valid ? snp.stq_s1_be : '0;

    // Committed-store bytes always win over the L1D copy of the line.
    always_comb begin
        merge_data = '0;
        merge_be   = (l1d_hit ? snp.l1d_s1_be : '0) | stq_be_eff;
        for (int b = 0; b < DATA_B_W; b++) begin
            if (stq_be_eff[b]) begin
                merge_data[b*8 +: 8] = snp.stq_s1_data[b*8 +: 8];
            end else if (l1d_hit) begin
                merge_data[b*8 +: 8] = snp.l1d_s1_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        tag_d       = tag_q;
        retry_d     = retry_q;
        boff_d      = boff_q;
        resp_data_d = resp_data_q;
        resp_be_d   = resp_be_q;
        resp_hit_d  = resp_hit_q;
        case (state_q)
            ST_IDLE: begin
                if (snp.snp_req_valid) begin
                    paddr_d = {snp.snp_req_paddr[PADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                    tag_d   = snp.snp_req_tag;
                    retry_d = '0;
                    state_d = ST_S0;
                end
            end
            ST_S0: begin
                state_d = ST_S1;
            end
            ST_S1: begin
                if (l1d_conflict) begin
                    if (retry_q < RTRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        boff_d  = '0;
                        state_d = ST_BACKOFF;
                    end else begin
                        // Out of retries: report the line as absent.
                        resp_data_d = '0;
                        resp_be_d   = '0;
                        resp_hit_d  = 1'b0;
                        state_d     = ST_RESP;
                    end
                end else begin
                    resp_data_d = merge_data;
                    resp_be_d   = merge_be;
                    resp_hit_d  = |merge_be;
                    state_d     = ST_RESP;
                end
            end
            ST_BACKOFF: begin
                if (boff_q == BOFF_W'(BACKOFF_CYC - 1)) begin
                    boff_d  = '0;
                    state_d = ST_S0;
                end else begin
                    boff_d = boff_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (snp.snp_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            tag_q       <= '0;
            retry_q     <= '0;
            boff_q      <= '0;
            resp_data_q <= '0;
            resp_be_q   <= '0;
            resp_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            tag_q       <= tag_d;
            retry_q     <= retry_d;
            boff_q      <= boff_d;
            resp_data_q <= resp_data_d;
            resp_be_q   <= resp_be_d;
            resp_hit_q  <= resp_hit_d;
        end
    end

    // Ready depends on state only, so acceptance never happens in the cycle RESP drains.
    assign snp.snp_req_ready  = (state_q == ST_IDLE);
    assign snp.l1d_s0_valid   = (state_q == ST_S0);
    assign snp.l1d_s0_paddr   = (state_q == ST_S0) ? paddr_q : '0;
    assign snp.stq_s0_valid   = (state_q == ST_S0);
    assign snp.stq_s0_paddr   = (state_q == ST_S0) ? paddr_q : '0;
    assign snp.snp_resp_valid = (state_q == ST_RESP);
    assign snp.snp_resp_data  = resp_data_q;
    assign snp.snp_resp_be    = resp_be_q;
    assign snp.snp_resp_hit   = resp_hit_q;
    assign snp.snp_resp_tag   = tag_q;

`ifndef SYNTHESIS
    // An s1 result outside S1 means the L1D/STQ pipelines lost sync with this block.
    always @(posedge i_clk) begin
        if (!i_reset && (state_q != ST_S1) && (snp.l1d_s1_valid || snp.stq_s1_valid)) begin
            $fatal(1, "msrh_l1d_snoop_ctrl: s1 response seen outside S1");
        end
    end
`endif

endmodule

// File: tb/tb_msrh_l1d_snoop_ctrl.sv
module tb_msrh_l1d_snoop_ctrl;

    localparam int PADDR_W = 56;
    localparam int DW      = 512;
    localparam int BW      = DW / 8;
    localparam int TAG_W   = 4;
    localparam int BOFF    = 2;
    localparam int STEP    = 2 + BOFF;

    localparam logic [1:0] S_NONE = 2'd0;
    localparam logic [1:0] S_HIT  = 2'd1;
    localparam logic [1:0] S_MISS = 2'd2;
    localparam logic [1:0] S_CONF = 2'd3;

    typedef struct {
        logic [1:0]    sts;
        logic          l1d_vld;
        logic [DW-1:0] l1d_data;
        logic [BW-1:0] l1d_be;
        logic          stq_vld;
        logic [DW-1:0] stq_data;
        logic [BW-1:0] stq_be;
    } pass_t;

    typedef struct {
        int                 cyc;
        logic [PADDR_W-1:0] paddr;
    } s0_exp_t;

    typedef struct {
        int               cyc;
        logic [DW-1:0]    data;
        logic [BW-1:0]    be;
        logic             hit;
        logic [TAG_W-1:0] tag;
        bit               chk_data;
    } resp_exp_t;

    logic i_clk = 1'b0;
    logic i_reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pass_t     pass_q[$];
    s0_exp_t   s0_q[$];
    resp_exp_t resp_q[$];

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    msrh_l1d_snoop_ctrl_if #(.PADDR_W(PADDR_W), .DCACHE_DATA_W(DW), .TAG_W(TAG_W)) bus ();

    msrh_l1d_snoop_ctrl #(
        .PADDR_W(PADDR_W), .DCACHE_DATA_W(DW), .TAG_W(TAG_W),
        .MAX_RETRY(7), .BACKOFF_CYC(BOFF)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .snp    (bus)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [DW-1:0] pat(input logic [7:0] seed);
        logic [DW-1:0] v;
        for (int b = 0; b < BW; b++) v[b*8 +: 8] = seed + 8'(b * 7);
        return v;
    endfunction

    function automatic pass_t mk(input logic [1:0] sts, input logic l1d_vld,
                                 input logic [DW-1:0] l1d_data, input logic [BW-1:0] l1d_be,
                                 input logic stq_vld, input logic [DW-1:0] stq_data,
                                 input logic [BW-1:0] stq_be);
        pass_t p;
        p.sts = sts; p.l1d_vld = l1d_vld; p.l1d_data = l1d_data; p.l1d_be = l1d_be;
        p.stq_vld = stq_vld; p.stq_data = stq_data; p.stq_be = stq_be;
        return p;
    endfunction

    // L1D/STQ model: answers each s0 with the next scripted pass, in the S1 cycle only.
    initial begin
        bus.l1d_s1_valid = 1'b0; bus.l1d_s1_status = 2'd0; bus.l1d_s1_data = '0; bus.l1d_s1_be = '0;
        bus.stq_s1_valid = 1'b0; bus.stq_s1_data = '0; bus.stq_s1_be = '0;
        forever begin
            @(negedge i_clk);
            if (!i_reset && bus.l1d_s0_valid) begin
                pass_t p;
                @(posedge i_clk); #1;
                if (pass_q.size() == 0) begin
                    flag("pass_script", "s0 issued with no scripted s1 left");
                end else begin
                    p = pass_q.pop_front();
                    bus.l1d_s1_valid = p.l1d_vld; bus.l1d_s1_status = p.sts;
                    bus.l1d_s1_data = p.l1d_data; bus.l1d_s1_be = p.l1d_be;
                    bus.stq_s1_valid = p.stq_vld; bus.stq_s1_data = p.stq_data;
                    bus.stq_s1_be = p.stq_be;
                end
                @(posedge i_clk); #1;
                bus.l1d_s1_valid = 1'b0;
                bus.stq_s1_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expected s0 issues and responses as the DUT presents them.
    initial begin
        bit        prev_v;
        s0_exp_t   e;
        resp_exp_t r;
        prev_v = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                prev_v = 1'b0;
                continue;
            end
            if (bus.l1d_s0_valid) begin
                if (s0_q.size() == 0) begin
                    flag("s0_unexpected", "s0 pulse with none expected");
                end else begin
                    e = s0_q.pop_front();
                    check("s0_cycle", cyc, e.cyc);
                    check("l1d_s0_paddr", bus.l1d_s0_paddr, e.paddr);
                    check("stq_s0_valid", bus.stq_s0_valid, 1'b1);
                    check("stq_s0_paddr", bus.stq_s0_paddr, e.paddr);
                end
            end
            if (bus.snp_resp_valid) begin
                if (resp_q.size() == 0) begin
                    flag("resp_unexpected", "response with none expected");
                end else begin
                    r = resp_q[0];
                    if (!prev_v) check("resp_cycle", cyc, r.cyc);
                    if (r.chk_data) check("resp_data", bus.snp_resp_data, r.data);
                    check("resp_be", bus.snp_resp_be, r.be);
                    check("resp_hit", bus.snp_resp_hit, r.hit);
                    check("resp_tag", bus.snp_resp_tag, r.tag);
                    check("req_ready_busy", bus.snp_req_ready, 1'b0);
                    if (bus.snp_resp_ready) void'(resp_q.pop_front());
                end
            end
            prev_v = bus.snp_resp_valid;
        end
    end

    task automatic issue(input logic [PADDR_W-1:0] pa, input logic [TAG_W-1:0] tg,
                         input int npass, input bit exp_resp, input logic [DW-1:0] edata,
                         input logic [BW-1:0] ebe, input logic ehit, input bit chk_data,
                         output int t_acc);
        int        k;
        s0_exp_t   e;
        resp_exp_t r;
        k = 0;
        t_acc = 0;
        @(posedge i_clk); #1;
        while (!bus.snp_req_ready && k < 50) begin
            @(posedge i_clk); #1;
            k++;
        end
        if (k >= 50) begin
            flag("req_ready_wait", "request never accepted within 50 cycles");
            return;
        end
        bus.snp_req_valid = 1'b1;
        bus.snp_req_paddr = pa;
        bus.snp_req_tag   = tg;
        t_acc = cyc;
        for (int i = 0; i < npass; i++) begin
            e.cyc   = t_acc + 1 + STEP * i;
            e.paddr = {pa[PADDR_W-1:6], 6'b0};
            s0_q.push_back(e);
        end
        if (exp_resp) begin
            r.cyc = t_acc + 3 + STEP * (npass - 1);
            r.data = edata; r.be = ebe; r.hit = ehit; r.tag = tg; r.chk_data = chk_data;
            resp_q.push_back(r);
        end
        @(posedge i_clk); #1;
        bus.snp_req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((s0_q.size() != 0 || resp_q.size() != 0) && k < 200) begin
            @(posedge i_clk);
            k++;
        end
        if (k >= 200) begin
            flag(name, "expected events still pending after 200 cycles");
            s0_q.delete();
            resp_q.delete();
        end
        repeat (2) @(posedge i_clk);
    endtask

    task automatic check_idle_outputs(input string tagname);
        check({tagname, "_req_ready"}, bus.snp_req_ready, 1'b1);
        check({tagname, "_l1d_s0_valid"}, bus.l1d_s0_valid, 1'b0);
        check({tagname, "_l1d_s0_paddr"}, bus.l1d_s0_paddr, '0);
        check({tagname, "_stq_s0_valid"}, bus.stq_s0_valid, 1'b0);
        check({tagname, "_stq_s0_paddr"}, bus.stq_s0_paddr, '0);
        check({tagname, "_resp_valid"}, bus.snp_resp_valid, 1'b0);
        check({tagname, "_resp_data"}, bus.snp_resp_data, '0);
        check({tagname, "_resp_be"}, bus.snp_resp_be, '0);
        check({tagname, "_resp_hit"}, bus.snp_resp_hit, 1'b0);
        check({tagname, "_resp_tag"}, bus.snp_resp_tag, '0);
    endtask

    initial begin
        logic [DW-1:0] all_ff, d_exp, stq_d, c_hit;
        logic [BW-1:0] all1;
        int            t, k;

        all_ff = {BW{8'hFF}};
        all1   = {BW{1'b1}};
        i_reset = 1'b1;
        bus.snp_req_valid = 1'b0; bus.snp_req_paddr = '0; bus.snp_req_tag = '0;
        bus.snp_resp_ready = 1'b1;
        #1;
        check_idle_outputs("rst");
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Clean hit.
        pass_q.push_back(mk(S_HIT, 1'b1, pat(8'h3C), all1, 1'b1, all_ff, '0));
        issue(56'h8000_0040, 4'd3, 1, 1'b1, pat(8'h3C), all1, 1'b1, 1'b1, t);
        drain("t1_hit");

        // Miss with store merge: only bytes 4..7 from the STQ survive.
        stq_d = {BW{8'h77}};
        stq_d[63:32] = 32'hDEAD_BEEF;
        d_exp = '0;
        d_exp[63:32] = 32'hDEAD_BEEF;
        pass_q.push_back(mk(S_MISS, 1'b1, all_ff, all1, 1'b1, stq_d, 64'hF0));
        issue(56'h8000_0080, 4'd5, 1, 1'b1, d_exp, 64'hF0, 1'b1, 1'b1, t);
        drain("t2_merge");

        // Hit with store override of byte 0; unaligned request address.
        d_exp = {BW{8'h11}};
        d_exp[7:0] = 8'hAA;
        pass_q.push_back(mk(S_HIT, 1'b1, {BW{8'h11}}, all1, 1'b1, {BW{8'hAA}}, 64'h1));
        issue(56'h1234_567F, 4'd9, 1, 1'b1, d_exp, all1, 1'b1, 1'b1, t);
        drain("t3_override");

        // Two conflicts (explicit, then missing L1D response) then a hit.
        pass_q.push_back(mk(S_CONF, 1'b1, all_ff, all1, 1'b1, all_ff, all1));
        pass_q.push_back(mk(S_HIT, 1'b0, all_ff, all1, 1'b1, all_ff, all1));
        pass_q.push_back(mk(S_HIT, 1'b1, pat(8'h81), all1, 1'b0, all_ff, all1));
        issue(56'h00AB_CDC0, 4'hA, 3, 1'b1, pat(8'h81), all1, 1'b1, 1'b1, t);
        drain("t4_retry");

        // Retry exhaustion: eight conflicts, empty response, no ninth s0.
        for (int i = 0; i < 8; i++)
            pass_q.push_back(mk(S_CONF, 1'b1, pat(8'(i)), all1, 1'b1, pat(8'(i + 1)), 64'hFF));
        issue(56'h0000_1000, 4'd2, 8, 1'b1, '0, '0, 1'b0, 1'b0, t);
        drain("t5_exhaust");

        // Status NONE acts as miss; invalid STQ bytes are ignored.
        pass_q.push_back(mk(S_NONE, 1'b1, all_ff, all1, 1'b0, all_ff, 64'hFF));
        issue(56'h0000_2040, 4'd6, 1, 1'b1, '0, '0, 1'b0, 1'b1, t);
        drain("t6_none");

        // Backpressure: response held 5 cycles with ready low.
        c_hit = pat(8'hC5);
        bus.snp_resp_ready = 1'b0;
        pass_q.push_back(mk(S_HIT, 1'b1, c_hit, all1, 1'b0, '0, '0));
        issue(56'h0000_3000, 4'd7, 1, 1'b1, c_hit, all1, 1'b1, 1'b1, t);
        k = 0;
        while (!bus.snp_resp_valid && k < 20) begin
            @(posedge i_clk); #1;
            k++;
        end
        if (k >= 20) flag("t7_resp_wait", "response never became valid");
        repeat (5) @(posedge i_clk);
        #1;
        bus.snp_resp_ready = 1'b1;
        drain("t7_backpressure");

        // Async reset in BACKOFF drops the snoop silently.
        pass_q.push_back(mk(S_CONF, 1'b1, all_ff, all1, 1'b0, '0, '0));
        issue(56'h0000_4000, 4'd4, 1, 1'b0, '0, '0, 1'b0, 1'b0, t);
        k = 0;
        while (cyc != t + 3 && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        #2;
        i_reset = 1'b1;
        #1;
        check_idle_outputs("rst_backoff");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk); #1;
        i_reset = 1'b0;
        repeat (12) @(posedge i_clk);
        drain("t8_reset");

        // Recovery after the mid-transaction reset.
        pass_q.push_back(mk(S_HIT, 1'b1, pat(8'h5A), all1, 1'b0, '0, '0));
        issue(56'hFF_FFFF_FFC0, 4'hF, 1, 1'b1, pat(8'h5A), all1, 1'b1, 1'b1, t);
        drain("t9_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
